cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM that sequences the RV32I datapath: instruction decoder, imm_gen, control_unit, operand mux and ALU.
- Fetches instructions over a req/ack instruction-memory handshake and holds the instruction register.
- Steps each instruction through DECODE/EXECUTE/MEM/WRITEBACK, pulses the register-file write, owns the PC, and halts with an error code on illegal instruction, bus timeout or misaligned target.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 16, maximum cycles waiting for an ack in FETCH or MEM before a timeout halt (must be >= 1).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata valid.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  instruction register, drives decoder/imm_gen.
- mem_read  in  1  control_unit MemRead.
- mem_write  in  1  control_unit MemWrite.
- reg_write  in  1  control_unit RegWrite.
- branch  in  1  control_unit Branch.
- jump  in  1  control_unit Jump.
- jalr  in  1  jump target comes from the ALU.
- ctrl_err  in  1  control_unit Error.
- reg_write_src  in  2  writeback source: 0 ALU, 1 memory, 2 pc+4, 3 imm.
- imm  in  32  immediate from imm_gen.
- alu_result  in  32  ALU result.
- branch_cond  in  1  ALU branch condition true.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  = latched alu_result.
- dmem_ack  in  1  data access complete.
- dmem_rdata  in  32  load data.
- rf_we  out  1  register-file write pulse.
- rf_wdata  out  32  writeback data.
- pc  out  32  current PC.
- state  out  3  encoded FSM state.
- halted  out  1  FSM in HALT.
- err_code  out  2  0 none, 1 illegal, 2 timeout, 3 misaligned.

Behaviour:
- Reset (async, any state, including mid-handshake):
  - state = IDLE, pc = RESET_PC, instr = 0.
  - imem_req, dmem_req, dmem_we, rf_we, halted = 0.
  - err_code = 0, rf_wdata = 0, timeout counter = 0.
- All outputs are registered or decoded from registered state (Moore).
- States and transitions:
  - IDLE (0): go to FETCH when run = 1.
  - FETCH (1): imem_req = 1.
    - On imem_ack: instr <= imem_rdata; go to DECODE.
    - An ack in the first FETCH cycle is legal.
  - DECODE (2): if ctrl_err, go to HALT with err 1; else go to EXECUTE.
  - EXECUTE (3): latch alu_result.
    - If mem_read or mem_write: go to MEM.
    - Otherwise: go to WRITEBACK.
  - MEM (4): dmem_req = 1, dmem_we = mem_write, dmem_addr = latched ALU result.
    - On dmem_ack: latch dmem_rdata; go to WRITEBACK.
  - WRITEBACK (5):
    - rf_we = reg_write for exactly one cycle; rf_wdata muxed by reg_write_src.
    - Compute next pc:
      - jalr: {alu_result[31:1], 1'b0}.
      - jump, or branch && branch_cond: pc + imm (32-bit wrap).
      - Otherwise: pc + 4 (wraps from 32'hFFFF_FFFC to 0).
    - If next pc[1:0] != 0: go to HALT with err 3; pc stays unchanged and rf_we is suppressed.
    - Otherwise pc <= next pc, then go to FETCH if run = 1, else IDLE.
  - HALT (6): halted = 1, err_code held. Exit only by reset.
- run is sampled only in IDLE and WRITEBACK. Deasserting run mid-instruction lets the instruction finish.
- Timeout:
  - Counter clears on entering FETCH or MEM and increments each cycle without an ack.
  - When it reaches TIMEOUT_CYCLES, go to HALT with err 2 and drop the request.
  - An ack in the same cycle the counter reaches the limit wins; no timeout.
- req stays high until ack; request outputs are 0 in every other state.
- Latency with zero-wait memory: 4 cycles for ALU/branch instructions, 5 for loads/stores.

Optional Feature:
- Macro: CPU_SEQUENCER_PERF_EN.
- Defined: adds outputs cycle_cnt (32 bits) and retired_cnt (32 bits).
  - cycle_cnt increments every cycle not in IDLE or HALT.
  - retired_cnt increments on each successful WRITEBACK exit.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Shared package cpu_pkg:
  - seq_state_t enum (IDLE=0 … HALT=6).
  - err_code_t enum.
  - wb_src_t enum (WB_ALU, WB_MEM, WB_PC4, WB_IMM).
  - Constant PC_STEP = 4.
- One sub-module: bus_timeout, the clear/increment/expire counter parameterised by TIMEOUT_CYCLES, instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset, then run = 1, zero-wait fetch of ADD with reg_write = 1, src 0, alu_result = 7:
  - rf_we pulses on cycle 4 with rf_wdata = 7.
  - pc goes 0 → 4.
  - imem_req is seen again on cycle 5.
- Branch with branch = 1, branch_cond = 1, imm = 32'hFFFF_FFF8 at pc = 8 → pc = 0, rf_we stays 0. With branch_cond = 0 → pc = 12.
- Load with 3-cycle dmem_ack delay and dmem_rdata = 32'hDEAD_BEEF, src 1:
  - dmem_req held 3 cycles, dmem_we = 0.
  - rf_wdata = 32'hDEAD_BEEF.
- imem_ack never asserted, TIMEOUT_CYCLES = 16 → HALT after 16 FETCH cycles, err_code = 2, imem_req = 0.
- ctrl_err = 1 in DECODE → HALT, err_code = 1. jalr with alu_result = 32'h0000_0006 → HALT, err_code = 3, pc unchanged.
- n_rst asserted mid-MEM → all outputs take reset values immediately; restart from RESET_PC on run.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: FSM states, error codes,
// writeback source select and the sequential PC step.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ILLEGAL    = 2'd1,
        ERR_TIMEOUT    = 2'd2,
        ERR_MISALIGNED = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_src_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/bus_timeout.sv
// Wait-cycle counter shared by the fetch and data buses; expire flags the last
// cycle of the allowed window so an ack arriving in that cycle still wins.
module bus_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback, halt.
// Optional macro CPU_SEQUENCER_PERF_EN adds cycle_cnt / retired_cnt counters.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        branch,
    input  logic        jump,
    input  logic        jalr,
    input  logic        ctrl_err,
    input  logic [1:0]  reg_write_src,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch_cond,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  err_code
`ifdef CPU_SEQUENCER_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    seq_state_t  state_q, state_d;
    err_code_t   err_q, err_d;
    logic [31:0] pc_q, instr_q, alu_q, npc_q, rf_wdata_q;
    logic        we_q, rf_we_q;
    logic [31:0] alu_cur, npc, wb_data;
    logic        waiting, bus_ack, expire, enter_wb;

    // Bus handshake: req is high for every cycle of FETCH/MEM until the cycle
    // ack is sampled high; the transfer completes on that edge and req drops.
    assign waiting = (state_q == FETCH) || (state_q == MEM);
    assign bus_ack = (state_q == FETCH) ? imem_ack : dmem_ack;

    bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (!waiting),
        .inc    (waiting && !bus_ack),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE:      if (run) state_d = FETCH;
            FETCH: begin
                if (imem_ack) state_d = DECODE;
                else if (expire) begin
                    state_d = HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DECODE: begin
                if (ctrl_err) begin
                    state_d = HALT;
                    err_d   = ERR_ILLEGAL;
                end else state_d = EXECUTE;
            end
            EXECUTE:   state_d = (mem_read || mem_write) ? MEM : WRITEBACK;
            MEM: begin
                if (dmem_ack) state_d = WRITEBACK;
                else if (expire) begin
                    state_d = HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            WRITEBACK: begin
                if (npc_q[1:0] != 2'b00) begin
                    state_d = HALT;
                    err_d   = ERR_MISALIGNED;
                end else state_d = run ? FETCH : IDLE;
            end
            HALT:      state_d = HALT;
            default:   state_d = IDLE;
        endcase
    end

    assign enter_wb = (state_d == WRITEBACK);

    // Next PC and writeback data are resolved on the way into WRITEBACK so the
    // write pulse can be registered and already know whether it is suppressed.
    always_comb begin
        alu_cur = (state_q == EXECUTE) ? alu_result : alu_q;
        if (jalr) npc = {alu_cur[31:1], 1'b0};
        else if (jump || (branch && branch_cond)) npc = pc_q + imm;
        else npc = pc_q + PC_STEP;
        wb_data = alu_cur;
        case (wb_src_t'(reg_write_src))
            WB_ALU:  wb_data = alu_cur;
            WB_MEM:  wb_data = dmem_rdata;
            WB_PC4:  wb_data = pc_q + PC_STEP;
            WB_IMM:  wb_data = imm;
            default: wb_data = alu_cur;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            err_q      <= ERR_NONE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            alu_q      <= '0;
            we_q       <= 1'b0;
            npc_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == FETCH && imem_ack) instr_q <= imem_rdata;
            if (state_q == EXECUTE) begin
                alu_q <= alu_result;
                we_q  <= mem_write;
            end
            if (enter_wb) begin
                npc_q      <= npc;
                rf_wdata_q <= wb_data;
                rf_we_q    <= reg_write && (npc[1:0] == 2'b00);
            end else begin
                rf_we_q <= 1'b0;
            end
            if (state_q == WRITEBACK && npc_q[1:0] == 2'b00) pc_q <= npc_q;
        end
    end

`ifdef CPU_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state_q != IDLE && state_q != HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (state_q == WRITEBACK && state_d != HALT) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = (state_q == MEM);
    assign dmem_we   = (state_q == MEM) && we_q;
    assign dmem_addr = alu_q;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rf_wdata_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign halted    = (state_q == HALT);
    assign err_code  = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, hand-written
// reset/run sequences and randomized instructions against a reference model.
module tb_cpu_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        n_rst, run, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, imm, alu_result, dmem_addr, dmem_rdata;
    logic        mem_read, mem_write, reg_write, branch, jump, jalr, ctrl_err, branch_cond;
    logic [1:0]  reg_write_src, err_code;
    logic        rf_we, halted;
    logic [31:0] rf_wdata, pc;
    logic [2:0]  state;
`ifdef CPU_SEQUENCER_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    // clock / reset block
    always #5 clk = ~clk;

    cpu_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_rst(n_rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch(branch), .jump(jump), .jalr(jalr), .ctrl_err(ctrl_err),
        .reg_write_src(reg_write_src), .imm(imm), .alu_result(alu_result), .branch_cond(branch_cond),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata), .pc(pc), .state(state),
        .halted(halted), .err_code(err_code)
`ifdef CPU_SEQUENCER_PERF_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    typedef struct {
        logic        mr, mw, rw, br, bc, jp, jr, cerr;
        logic [1:0]  src;
        logic [31:0] word, imm, alu, ldata;
        int          iwait, dwait;
    } ins_t;

    typedef struct {
        int          cycles, fetch, we_cnt, dreq;
        logic [31:0] wdata, pc, iaddr, daddr, instr;
        logic        dwe, halted, ireq, timeout;
        logic [1:0]  err;
    } obs_t;

    typedef struct {
        ins_t i;
        obs_t e;
        bit   rst_after;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ins_t mkins(input logic [31:0] word, input logic mr, mw, rw, br, bc, jp, jr, cerr,
                                   input logic [1:0] src, input logic [31:0] imm_v, alu, ldata,
                                   input int iwait, dwait);
        ins_t t;
        t.word = word; t.mr = mr; t.mw = mw; t.rw = rw; t.br = br; t.bc = bc; t.jp = jp;
        t.jr = jr; t.cerr = cerr; t.src = src; t.imm = imm_v; t.alu = alu; t.ldata = ldata;
        t.iwait = iwait; t.dwait = dwait;
        return t;
    endfunction

    function automatic obs_t mkexp(input int cycles, fetch, we_cnt, input logic [31:0] wdata, pcv,
                                   input int dreq, input logic dwe, input logic [31:0] daddr,
                                   input logic [1:0] err);
        obs_t e;
        e = '{default: 0};
        e.cycles = cycles; e.fetch = fetch; e.we_cnt = we_cnt; e.wdata = wdata; e.pc = pcv;
        e.dreq = dreq; e.dwe = dwe; e.daddr = daddr; e.err = err;
        e.halted = (err != 2'd0);
        e.ireq   = (err == 2'd0);
        return e;
    endfunction

    // Reference model: one instruction's visible effect from the architectural rules.
    function automatic obs_t model(input ins_t t, input logic [31:0] pc0);
        obs_t        e;
        logic [31:0] tgt;
        e = '{default: 0};
        e.pc = pc0; e.instr = t.word;
        e.fetch = t.iwait + 1;
        e.cycles = t.iwait + 2;
        if (t.cerr) begin
            e.halted = 1; e.err = 2'd1;
            return e;
        end
        e.cycles += 1;
        if (t.mr || t.mw) begin
            e.dreq = t.dwait + 1; e.cycles += e.dreq; e.dwe = t.mw; e.daddr = t.alu;
        end
        e.cycles += 1;
        if (t.jr) tgt = t.alu & 32'hFFFF_FFFE;
        else if (t.jp || (t.br && t.bc)) tgt = pc0 + t.imm;
        else tgt = pc0 + 32'd4;
        if (tgt % 4 != 0) begin
            e.halted = 1; e.err = 2'd3;
            return e;
        end
        e.pc = tgt; e.ireq = 1;
        if (t.rw) begin
            e.we_cnt = 1;
            case (t.src)
                2'd0:    e.wdata = t.alu;
                2'd1:    e.wdata = t.ldata;
                2'd2:    e.wdata = pc0 + 32'd4;
                default: e.wdata = t.imm;
            endcase
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ctl(input ins_t t);
        mem_read = t.mr; mem_write = t.mw; reg_write = t.rw; branch = t.br; branch_cond = t.bc;
        jump = t.jp; jalr = t.jr; ctrl_err = t.cerr; reg_write_src = t.src; imm = t.imm;
        alu_result = t.alu; dmem_rdata = t.ldata; imem_rdata = t.word;
    endtask

    // Driver: starts with the DUT in its first FETCH cycle, acts as both memories.
    task automatic do_instr(input ins_t t, output obs_t o);
        bit fetched;
        int fc, dc;
        o = '{default: 0};
        o.timeout = 1;
        fetched = 0; fc = 0; dc = 0;
        drive_ctl(t);
        for (int c = 0; c < 200; c++) begin
            if (halted) begin o.timeout = 0; break; end
            if (fetched && (imem_req || state == 3'd0)) begin o.timeout = 0; break; end
            imem_ack = imem_req && (fc == t.iwait);
            if (imem_req) begin fc++; if (imem_ack) fetched = 1; end
            dmem_ack = dmem_req && (dc == t.dwait);
            if (dmem_req) begin dc++; o.dwe = dmem_we; o.daddr = dmem_addr; end
            if (rf_we) begin o.we_cnt++; o.wdata = rf_wdata; end
            o.cycles++;
            step();
        end
        imem_ack = 0; dmem_ack = 0;
        o.fetch = fc; o.dreq = dc; o.pc = pc; o.iaddr = imem_addr; o.err = err_code;
        o.halted = halted; o.ireq = imem_req; o.instr = instr;
    endtask

    task automatic cmp(input string n, input obs_t o, input obs_t e);
        check({n, ".budget_expired"}, o.timeout, 1'b0);
        check({n, ".cycles"}, o.cycles, e.cycles);
        check({n, ".fetch_cycles"}, o.fetch, e.fetch);
        check({n, ".rf_we_pulses"}, o.we_cnt, e.we_cnt);
        if (e.we_cnt > 0) check({n, ".rf_wdata"}, o.wdata, e.wdata);
        check({n, ".pc"}, o.pc, e.pc);
        check({n, ".imem_addr"}, o.iaddr, e.pc);
        check({n, ".halted"}, o.halted, e.halted);
        check({n, ".err_code"}, o.err, e.err);
        check({n, ".imem_req"}, o.ireq, e.ireq);
        check({n, ".instr"}, o.instr, e.instr);
        check({n, ".dmem_cycles"}, o.dreq, e.dreq);
        if (e.dreq > 0) begin
            check({n, ".dmem_we"}, o.dwe, e.dwe);
            check({n, ".dmem_addr"}, o.daddr, e.daddr);
        end
    endtask

    task automatic do_reset();
        n_rst = 0; run = 0; imem_ack = 0; dmem_ack = 0;
        step(); step();
        n_rst = 1; run = 1;
        step();
    endtask

    task automatic add(input ins_t t, input obs_t e, input bit rst);
        vec_t v;
        v.i = t; v.e = e; v.e.instr = t.word; v.rst_after = rst;
        vecs.push_back(v);
    endtask

    initial begin
        obs_t        o, e;
        ins_t        t;
        logic [31:0] pc_m, r;
        int          quiet;

        n_rst = 0; run = 0; imem_ack = 0; dmem_ack = 0;
        drive_ctl(mkins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("reset.state", state, 3'd0);
        check("reset.pc", pc, 32'h0);
        check("reset.instr", instr, 32'h0);
        check("reset.reqs", {imem_req, dmem_req, dmem_we, rf_we, halted}, 5'b0);
        check("reset.err_code", err_code, 2'd0);
        check("reset.rf_wdata", rf_wdata, 32'h0);
        step();
        n_rst = 1; run = 1;
        step();

        //          word           mr mw rw br bc jp jr ce src imm            alu            ldata          iw   dw
        add(mkins(32'h0070_0393, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h7,         32'h0,          0,   0),
            mkexp(4, 1, 1, 32'h7, 32'h4, 0, 0, 0, 0), 0);
        add(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 0, 0, 32'h8, 0, 0, 0, 0), 0);
        add(mkins(32'hFE00_0CE3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 0, 0, 32'h0, 0, 0, 0, 0), 0);
        add(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 0, 0, 32'h4, 0, 0, 0, 0), 0);
        add(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,          2,   0),
            mkexp(6, 3, 0, 0, 32'h8, 0, 0, 0, 0), 0);
        add(mkins(32'hFE00_0CE3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 0, 0, 32'hC, 0, 0, 0, 0), 0);
        add(mkins(32'h1000_2503, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h100,       32'h100,       32'hDEAD_BEEF,  0,   2),
            mkexp(7, 1, 1, 32'hDEAD_BEEF, 32'h10, 3, 0, 32'h100, 0), 0);
        add(mkins(32'h20A0_2223, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h204,       32'h204,       32'h0,          0,   0),
            mkexp(5, 1, 0, 0, 32'h14, 1, 1, 32'h204, 0), 0);
        add(mkins(32'h0400_00EF, 0, 0, 1, 0, 0, 1, 0, 0, 2, 32'h40,        32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 1, 32'h18, 32'h54, 0, 0, 0, 0), 0);
        add(mkins(32'h1234_52B7, 0, 0, 1, 0, 0, 0, 0, 0, 3, 32'h1234_5000, 32'h0,         32'h0,          0,   0),
            mkexp(4, 1, 1, 32'h1234_5000, 32'h58, 0, 0, 0, 0), 0);
        add(mkins(32'h0010_80E7, 0, 0, 1, 0, 0, 0, 1, 0, 2, 32'h1,         32'h101,       32'h0,          0,   0),
            mkexp(4, 1, 1, 32'h5C, 32'h100, 0, 0, 0, 0), 0);
        add(mkins(32'h0060_00E7, 0, 0, 1, 0, 0, 0, 1, 0, 2, 32'h6,         32'h6,         32'h0,          0,   0),
            mkexp(4, 1, 0, 0, 32'h100, 0, 0, 0, 3), 1);
        add(mkins(32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         32'h0,          0,   0),
            mkexp(2, 1, 0, 0, 32'h0, 0, 0, 0, 1), 1);
        add(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,        100,   0),
            mkexp(TO, TO, 0, 0, 32'h0, 0, 0, 0, 2), 1);
        vecs[vecs.size()-1].e.instr = 32'h0;
        add(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,      TO-1,   0),
            mkexp(TO + 3, TO, 0, 0, 32'h4, 0, 0, 0, 0), 0);
        add(mkins(32'h0000_2503, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h80,        32'h0,          0, 100),
            mkexp(TO + 3, 1, 0, 0, 32'h4, TO, 0, 32'h80, 2), 1);

        for (int k = 0; k < vecs.size(); k++) begin
            do_instr(vecs[k].i, o);
            cmp($sformatf("vec%0d", k), o, vecs[k].e);
            if (vecs[k].rst_after) do_reset();
        end

        // run deasserted mid-instruction: finishes, parks in IDLE, resumes on run
        run = 0;
        do_instr(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o);
        e = mkexp(4, 1, 0, 0, 32'h4, 0, 0, 0, 0);
        e.ireq = 0; e.instr = 32'h0000_0013;
        cmp("run_low", o, e);
        quiet = 0;
        for (int c = 0; c < 3; c++) begin
            if (!imem_req) quiet++;
            step();
        end
        check("run_low.idle_no_req", quiet, 3);
        run = 1;
        step();
        check("run_resume.imem_req", imem_req, 1'b1);
        check("run_resume.imem_addr", imem_addr, 32'h4);
        do_instr(mkins(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), o);
        e = mkexp(4, 1, 0, 0, 32'h8, 0, 0, 0, 0); e.instr = 32'h0000_0013;
        cmp("run_resume", o, e);

        // asynchronous reset in the middle of a data access
        drive_ctl(mkins(32'h0000_2503, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 32'h1, 0, 0));
        for (int c = 0; c < 10 && !dmem_req; c++) begin
            imem_ack = imem_req;
            step();
        end
        imem_ack = 0;
        check("midmem.reached_mem", dmem_req, 1'b1);
        step();
        n_rst = 0;
        #2;
        check("midmem.state", state, 3'd0);
        check("midmem.pc", pc, 32'h0);
        check("midmem.instr", instr, 32'h0);
        check("midmem.reqs", {imem_req, dmem_req, dmem_we, rf_we, halted}, 5'b0);
        check("midmem.err_rfw", {30'h0, err_code} | rf_wdata, 32'h0);
        n_rst = 1; run = 1;
        step();
        check("midmem.restart_addr", imem_addr, 32'h0);
        do_instr(mkins(32'h0070_0393, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h7, 0, 0, 0), o);
        e = mkexp(4, 1, 1, 32'h7, 32'h4, 0, 0, 0, 0); e.instr = 32'h0070_0393;
        cmp("midmem.restart", o, e);

        // randomized instruction stream against the reference model
        do_reset();
        pc_m = 32'h0;
        for (int k = 0; k < 40; k++) begin
            r = $urandom();
            t = mkins($urandom(), 0, 0, 0, 0, 0, 0, 0, 0, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? r : (r & ~32'h3), $urandom(), $urandom(),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            t.rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: t.mr = 1;
                1: t.mw = 1;
                2: begin t.br = 1; t.bc = 1'($urandom_range(0, 1)); end
                3: t.jp = 1;
                4: begin t.jr = 1; if ($urandom_range(0, 3) != 0) t.alu = t.alu & ~32'h2; end
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) t.cerr = 1;
            e = model(t, pc_m);
            do_instr(t, o);
            cmp($sformatf("rnd%0d", k), o, e);
            if (e.halted) begin
                do_reset();
                pc_m = 32'h0;
            end else begin
                pc_m = e.pc;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
